// File: rtl/line_assembler_if.sv
// line_assembler_if: symbol input, line acknowledge and buffer readback of the line assembler.
interface line_assembler_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 6
);
    logic              i_data_latch;
    logic [DATA_W-1:0] i_data;
    logic              i_line_ack;
    logic [AW-1:0]     i_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_line_ready;
    logic              o_line_pulse;
    logic [AW:0]       o_line_len;
    logic              o_overflow;
    logic              o_dropped;

    modport master (
        output i_data_latch, i_data, i_line_ack, i_rd_addr,
        input  o_rd_data, o_line_ready, o_line_pulse, o_line_len, o_overflow, o_dropped
    );

    modport slave (
        input  i_data_latch, i_data, i_line_ack, i_rd_addr,
        output o_rd_data, o_line_ready, o_line_pulse, o_line_len, o_overflow, o_dropped
    );
endinterface

// File: rtl/line_assembler.sv
// line_assembler: buffers received symbols into a line, matches a 1/2-symbol terminator and holds the line until acked.
module line_assembler #(
    parameter int                DATA_W     = 8,
    parameter int                DEPTH      = 64,
    parameter int                TERM_LEN   = 2,
    parameter logic [DATA_W-1:0] TERM0      = 8'h0D,
    parameter logic [DATA_W-1:0] TERM1      = 8'h0A,
    parameter bit                STRIP_TERM = 1'b1
) (
    input logic             i_clk,
    input logic             i_rst_n,
    line_assembler_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] ADJ  = (AW+1)'(STRIP_TERM ? TERM_LEN : 0);

    typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_count, r_line_len;
    logic [DATA_W-1:0] r_prev, r_rd_data;
    logic              r_prev_valid, r_line_pulse, r_overflow, r_dropped;
    logic              w_match, w_track, w_store, w_done, w_overflow, w_drop, w_resync, w_restart;

    always_comb begin
        w_match    = (TERM_LEN == 1) ? (bus.i_data == TERM1)
                                     : (r_prev_valid && r_prev == TERM0 && bus.i_data == TERM1);
        w_track    = bus.i_data_latch && r_state != HOLD;
        w_store    = w_track && r_state == COLLECT && r_count != FULL;
        w_done     = w_store && w_match;
        w_overflow = w_track && r_state == COLLECT && r_count == FULL;
        w_drop     = bus.i_data_latch && r_state == HOLD;
        w_resync   = w_track && r_state == DISCARD && w_match;
        w_restart  = w_resync || (r_state == HOLD && bus.i_line_ack);
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_state <= COLLECT;
        else
            r_state <= w_state_nxt;

    // Every qualifier above is already gated by the state it applies to.
    always_comb begin
        w_state_nxt = w_done ? HOLD : w_overflow ? DISCARD : w_restart ? COLLECT : r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_line_len   <= '0;
            r_line_pulse <= 1'b0;
            r_overflow   <= 1'b0;
            r_dropped    <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_count      <= w_restart ? '0 : w_store ? r_count + ONE : r_count;
            r_prev       <= w_track ? bus.i_data : r_prev;
            r_prev_valid <= !w_restart && (w_track || r_prev_valid);
            r_line_len   <= w_done ? r_count + ONE - ADJ : r_line_len;
            r_line_pulse <= w_done;
            r_overflow   <= w_overflow;
            r_dropped    <= w_drop;
            r_rd_data    <= r_mem[bus.i_rd_addr];
        end
    end

    // Line storage is deliberately left out of reset.
    always_ff @(posedge i_clk)
        if (w_store)
            r_mem[r_count[AW-1:0]] <= bus.i_data;

    always_comb begin
        bus.o_line_ready = r_state == HOLD;
        bus.o_line_pulse = r_line_pulse;
        bus.o_line_len   = r_line_len;
        bus.o_overflow   = r_overflow;
        bus.o_dropped    = r_dropped;
        bus.o_rd_data    = r_rd_data;
    end
endmodule

// File: tb/tb_line_assembler.sv
// tb_line_assembler: directed and random symbol streams on a CR/LF stripping instance and a LF-only non-stripping instance.
module tb_line_assembler;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_assembler_if #(.DATA_W(8), .AW(6)) b0 ();
    line_assembler_if #(.DATA_W(8), .AW(6)) b1 ();

    line_assembler u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave));
    line_assembler #(.TERM_LEN(1), .STRIP_TERM(1'b0)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave));

    assign b1.i_data_latch = b0.i_data_latch;
    assign b1.i_data       = b0.i_data;
    assign b1.i_line_ack   = b0.i_line_ack;
    assign b1.i_rd_addr    = b0.i_rd_addr;

    logic [7:0] rd  [2];
    logic [6:0] len [2];
    logic       rdy [2], pls [2], ovf [2], drp [2];
    assign rd[0]  = b0.o_rd_data;    assign rd[1]  = b1.o_rd_data;
    assign len[0] = b0.o_line_len;   assign len[1] = b1.o_line_len;
    assign rdy[0] = b0.o_line_ready; assign rdy[1] = b1.o_line_ready;
    assign pls[0] = b0.o_line_pulse; assign pls[1] = b1.o_line_pulse;
    assign ovf[0] = b0.o_overflow;   assign ovf[1] = b1.o_overflow;
    assign drp[0] = b0.o_dropped;    assign drp[1] = b1.o_dropped;

    // Reference model: one line as an array plus held/discarding flags per instance.
    int         tl    [2];
    bit         strip [2];
    logic [7:0] m_buf [2][64];
    bit         m_wr  [2][64];
    int         m_cnt [2], m_len [2], m_last [2];
    bit         m_hold [2], m_disc [2];
    bit         e_pls [2], e_ovf [2], e_drp [2], e_rd_ok [2];
    logic [7:0] e_rd  [2];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_len[k] = 0; m_last[k] = -1;
            m_hold[k] = 0; m_disc[k] = 0;
            e_pls[k] = 0; e_ovf[k] = 0; e_drp[k] = 0; e_rd_ok[k] = 0;
        end
    endtask

    task automatic model(input int k, input bit lat, input logic [7:0] d, input bit ack);
        bit term;
        e_pls[k] = 0; e_ovf[k] = 0; e_drp[k] = 0;
        term = (tl[k] == 1) ? (d == LF) : (m_last[k] == int'(CR) && d == LF);
        if (m_hold[k]) begin
            e_drp[k] = lat;
            if (ack) begin
                m_hold[k] = 0; m_cnt[k] = 0; m_last[k] = -1;
            end
        end else if (lat) begin
            if (m_disc[k]) begin
                m_last[k] = term ? -1 : int'(d);
                if (term) begin
                    m_disc[k] = 0; m_cnt[k] = 0;
                end
            end else if (m_cnt[k] == 64) begin
                e_ovf[k] = 1; m_disc[k] = 1; m_last[k] = int'(d);
            end else begin
                m_buf[k][m_cnt[k]] = d;
                m_wr[k][m_cnt[k]] = 1;
                m_cnt[k]++;
                m_last[k] = int'(d);
                if (term) begin
                    m_hold[k] = 1; e_pls[k] = 1;
                    m_len[k] = m_cnt[k] - (strip[k] ? tl[k] : 0);
                end
            end
        end
    endtask

    task automatic step(input bit lat, input logic [7:0] d, input bit ack);
        b0.i_data_latch = lat; b0.i_data = d; b0.i_line_ack = ack;
        for (int k = 0; k < 2; k++) begin
            e_rd[k] = m_buf[k][b0.i_rd_addr];
            e_rd_ok[k] = m_wr[k][b0.i_rd_addr];
            model(k, lat, d, ack);
        end
        @(posedge clk); #1;
        b0.i_data_latch = 1'b0; b0.i_line_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("line_ready", k, rdy[k], m_hold[k]);
            chk("line_pulse", k, pls[k], e_pls[k]);
            chk("overflow", k, ovf[k], e_ovf[k]);
            chk("dropped", k, drp[k], e_drp[k]);
            if (m_hold[k]) chk("line_len", k, len[k], m_len[k]);
            if (e_rd_ok[k]) chk("rd_data", k, rd[k], e_rd[k]);
        end
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
    endtask

    task automatic read_line(input int k);
        for (int i = 0; i < m_len[k]; i++) begin
            b0.i_rd_addr = 6'(i);
            step(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, rdy[k], 0);
            chk("rst_pulse", k, pls[k], 0);
            chk("rst_overflow", k, ovf[k], 0);
            chk("rst_dropped", k, drp[k], 0);
            chk("rst_len", k, len[k], 0);
            chk("rst_rd_data", k, rd[k], 0);
        end
    endtask

    initial begin
        tl[0] = 2; strip[0] = 1'b1;
        tl[1] = 1; strip[1] = 1'b0;
        b0.i_data_latch = 1'b0; b0.i_data = 8'h00; b0.i_line_ack = 1'b0; b0.i_rd_addr = '0;
        mreset();
        #12 check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;

        send("AB\r\n");
        read_line(0); read_line(1);
        step(1'b0, 8'h00, 1'b1);

        send("X\r\n");
        send("Y");
        step(1'b0, 8'h00, 1'b1);
        send("Z\r\n");
        read_line(0);
        step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 65; i++) step(1'b1, 8'h61, 1'b0);
        send("Q\r\n");
        send("OK\r\n");
        read_line(0);
        step(1'b0, 8'h00, 1'b1);

        send("hi\n");
        send("\r\n");
        read_line(0); read_line(1);
        step(1'b0, 8'h00, 1'b1);
        send("P\r\n");
        send("\r");
        step(1'b0, 8'h00, 1'b1);
        send("\n");
        send("\r\n");
        read_line(0);
        step(1'b0, 8'h00, 1'b1);

        send("\r\n");
        step(1'b0, 8'h00, 1'b1);
        send("AB");
        rst_n = 1'b0;
        #1 check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mreset();
        send("C\r\n");
        read_line(0);
        step(1'b0, 8'h00, 1'b1);

        send("M\r\n");
        step(1'b1, 8'h57, 1'b1);
        send("\r\n");
        read_line(1);
        step(1'b0, 8'h00, 1'b1);

        for (int n = 0; n < 2000; n++) begin
            bit quiet;
            int r;
            logic [7:0] d;
            quiet = (n % 500) < 150;
            r = int'($urandom_range(0, 9));
            d = (!quiet && r < 2) ? CR : (!quiet && r < 4) ? LF : 8'(8'h20 + $urandom_range(0, 94));
            b0.i_rd_addr = 6'($urandom_range(0, 63));
            step(quiet ? 1'b1 : 1'($urandom_range(0, 1)), d, $urandom_range(0, 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
